// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle between the hazard/memory sources and pipe_ctrl; slave is the sequencer.
// Perf-counter signals exist only when PIPE_PERF_CNT_EN is defined.
interface pipe_ctrl_if;
    logic       hazStall;
    logic       brTaken;
    logic       imemStall;
    logic       dmemStall;
    logic       haltW;
    logic       pcWrEn;
    logic       ifidWrEn;
    logic       idexWrEn;
    logic       exmemWrEn;
    logic       memwbWrEn;
    logic       ifidFlush;
    logic       idexFlush;
    logic       halted;
    logic       memTimeout;
    logic [1:0] ctrlState;
`ifdef PIPE_PERF_CNT_EN
    logic [15:0] stallCycles;
    logic [15:0] flushCycles;
    logic [15:0] instRetired;

    modport master (
        output hazStall, brTaken, imemStall, dmemStall, haltW,
        input  pcWrEn, ifidWrEn, idexWrEn, exmemWrEn, memwbWrEn,
        input  ifidFlush, idexFlush, halted, memTimeout, ctrlState,
        input  stallCycles, flushCycles, instRetired
    );
    modport slave (
        input  hazStall, brTaken, imemStall, dmemStall, haltW,
        output pcWrEn, ifidWrEn, idexWrEn, exmemWrEn, memwbWrEn,
        output ifidFlush, idexFlush, halted, memTimeout, ctrlState,
        output stallCycles, flushCycles, instRetired
    );
`else
    modport master (
        output hazStall, brTaken, imemStall, dmemStall, haltW,
        input  pcWrEn, ifidWrEn, idexWrEn, exmemWrEn, memwbWrEn,
        input  ifidFlush, idexFlush, halted, memTimeout, ctrlState
    );
    modport slave (
        input  hazStall, brTaken, imemStall, dmemStall, haltW,
        output pcWrEn, ifidWrEn, idexWrEn, exmemWrEn, memwbWrEn,
        output ifidFlush, idexFlush, halted, memTimeout, ctrlState
    );
`endif
endinterface

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer driving the pipeline-register write enables and flushes; PIPE_PERF_CNT_EN adds perf counters.
// Latency: Mealy, controls react to stall/branch inputs in the same cycle; state updates on posedge clk.
// Backpressure: dmemStall freezes every stage; imemStall/hazStall hold only the front end.
module pipe_ctrl #(
    parameter int FLUSH_CYC = 2,
    parameter int MAX_STALL = 200
) (
    input  logic        clk,
    input  logic        rst_n,
    pipe_ctrl_if.slave  pif
);
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DMEM  = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYC - 1);
    localparam logic [7:0] STALL_MAX  = 8'(MAX_STALL);

    state_e     state_q, state_d;
    logic [3:0] flush_cnt_q, flush_cnt_d;
    logic [7:0] stall_cnt_q, stall_cnt_d;
    logic       halted_q, halted_d;
    logic       mem_timeout_q, mem_timeout_d;

    logic pc_wr, ifid_wr, idex_wr, exmem_wr, memwb_wr;
    logic ifid_flush, idex_flush, halt_now;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            flush_cnt_q   <= '0;
            stall_cnt_q   <= '0;
            halted_q      <= 1'b0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
            halted_q      <= halted_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        stall_cnt_d   = '0;
        halted_d      = halted_q;
        mem_timeout_d = mem_timeout_q;
        pc_wr         = 1'b1;
        ifid_wr       = 1'b1;
        idex_wr       = 1'b1;
        exmem_wr      = 1'b1;
        memwb_wr      = 1'b1;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        halt_now      = 1'b0;

        if (!rst_n) begin
            {pc_wr, ifid_wr, idex_wr, exmem_wr, memwb_wr} = '0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (state_q == ST_HALT || pif.haltW) begin
            {pc_wr, ifid_wr, idex_wr, exmem_wr, memwb_wr} = '0;
            halt_now = 1'b1;
            halted_d = 1'b1;
            state_d  = ST_HALT;
        end else if (pif.dmemStall) begin
            // Full freeze; flush_cnt is held so an interrupted flush resumes afterwards.
            {pc_wr, ifid_wr, idex_wr, exmem_wr, memwb_wr} = '0;
            state_d     = ST_DMEM;
            stall_cnt_d = (stall_cnt_q == STALL_MAX) ? stall_cnt_q : stall_cnt_q + 8'd1;
            if (stall_cnt_d == STALL_MAX) begin
                mem_timeout_d = 1'b1;
            end
        end else if (pif.brTaken) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            flush_cnt_d = FLUSH_LOAD;
            state_d     = (FLUSH_CYC > 1) ? ST_FLUSH : ST_RUN;
        end else if (flush_cnt_q != 4'd0) begin
            // Reached from FLUSH, or from DMEM when the freeze interrupted a flush.
            ifid_flush  = 1'b1;
            idex_flush  = pif.hazStall;
            flush_cnt_d = flush_cnt_q - 4'd1;
            state_d     = (flush_cnt_d == 4'd0) ? ST_RUN : ST_FLUSH;
        end else begin
            state_d = ST_RUN;
            if (pif.hazStall) begin
                pc_wr      = 1'b0;
                ifid_wr    = 1'b0;
                idex_flush = 1'b1;
            end else if (pif.imemStall) begin
                pc_wr      = 1'b0;
                ifid_flush = 1'b1;
            end
        end
    end

    assign pif.pcWrEn     = pc_wr;
    assign pif.ifidWrEn   = ifid_wr;
    assign pif.idexWrEn   = idex_wr;
    assign pif.exmemWrEn  = exmem_wr;
    assign pif.memwbWrEn  = memwb_wr;
    assign pif.ifidFlush  = ifid_flush;
    assign pif.idexFlush  = idex_flush;
    assign pif.halted     = halted_q | halt_now;
    assign pif.memTimeout = mem_timeout_q;
    assign pif.ctrlState  = state_q;

`ifdef PIPE_PERF_CNT_EN
    logic [15:0] stall_cyc_q, stall_cyc_d;
    logic [15:0] flush_cyc_q, flush_cyc_d;
    logic [15:0] inst_ret_q, inst_ret_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cyc_q <= '0;
            flush_cyc_q <= '0;
            inst_ret_q  <= '0;
        end else begin
            stall_cyc_q <= stall_cyc_d;
            flush_cyc_q <= flush_cyc_d;
            inst_ret_q  <= inst_ret_d;
        end
    end

    always_comb begin
        stall_cyc_d = stall_cyc_q;
        flush_cyc_d = flush_cyc_q;
        inst_ret_d  = inst_ret_q;
        if (!pc_wr && !halt_now && stall_cyc_q != 16'hFFFF) begin
            stall_cyc_d = stall_cyc_q + 16'd1;
        end
        if (ifid_flush && rst_n && flush_cyc_q != 16'hFFFF) begin
            flush_cyc_d = flush_cyc_q + 16'd1;
        end
        if (memwb_wr && inst_ret_q != 16'hFFFF) begin
            inst_ret_d = inst_ret_q + 16'd1;
        end
    end

    assign pif.stallCycles = stall_cyc_q;
    assign pif.flushCycles = flush_cyc_q;
    assign pif.instRetired = inst_ret_q;
`endif
endmodule
